// File: rtl/mc_main_control.sv
// mc_main_control
// Main control FSM for the multicycle CPU. Each instruction is stepped through
// fetch, decode, execute, memory and writeback cycles. The control outputs
// depend only on the current state. The one exception is pc_en, which also
// uses the ALU zero flag while in BEQ.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset (state -> FETCH)
//   opcode[5:0]  instruction[31:26] from the IR, sampled in DECODE/MEMADR
//   zero         ALU zero flag, used only in BEQ
//   pc_en        PC load = pc_write | (pc_write_cond & zero)
//   iord         memory address select (0 PC, 1 ALUOut)
//   mem_read     memory read
//   mem_write    memory write
//   ir_write     instruction register load
//   mem_to_reg   register write data select (0 ALUOut, 1 MDR)
//   reg_dst      register write address select (0 rt, 1 rd)
//   reg_write    register-file write enable
//   alu_src_a    ALU A select (0 PC, 1 reg A)
//   alu_src_b    ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   alu_op       00 add, 01 sub, 10 funct
//   pc_source    00 ALU, 01 ALUOut, 10 jump target
//   state[3:0]   current state code (debug)
//   illegal      high while in HALT
module mc_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JMP    = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_pc_write;
  logic   w_pc_write_cond;
  logic   w_ir_write;
  logic   w_mem_write;
  logic   w_reg_write;

  // Next-state logic. Codes 12-14 are not reachable and fall back to FETCH.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) w_next = S_MEMADR;
        else if (opcode == OP_RTYPE)            w_next = S_EXEC;
        else if (opcode == OP_BEQ)              w_next = S_BEQ;
        else if (opcode == OP_J)                w_next = S_JMP;
        else if (opcode == OP_ADDI)             w_next = S_ADDIEX;
        else                                    w_next = S_HALT;
      end
      S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = S_RWB;
      S_ADDIEX: w_next = S_ADDIWB;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  // The state register is the only storage in the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Moore output decode from the state register.
  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_write     = 1'b0;
    w_reg_write     = 1'b0;
    iord            = 1'b0;
    mem_read        = 1'b0;
    mem_to_reg      = 1'b0;
    reg_dst         = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    alu_op          = 2'b00;
    pc_source       = 2'b00;
    illegal         = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read   = 1'b1;
        w_ir_write = 1'b1;
        alu_src_b  = 2'b01;
        w_pc_write = 1'b1;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        iord        = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        w_reg_write = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BEQ: begin
        alu_src_a       = 1'b1;
        alu_op          = 2'b01;
        w_pc_write_cond = 1'b1;
        pc_source       = 2'b01;
      end
      S_JMP: begin
        w_pc_write = 1'b1;
        pc_source  = 2'b10;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_HALT:   illegal = 1'b1;
      default: ;
    endcase
  end

  // The write enables are gated by rst directly, so none of them can pulse
  // while reset is held. The async reset already forces FETCH, which puts
  // every other output at its FETCH value.
  assign pc_en     = (w_pc_write | (w_pc_write_cond & zero)) & ~rst;
  assign ir_write  = w_ir_write  & ~rst;
  assign mem_write = w_mem_write & ~rst;
  assign reg_write = w_reg_write & ~rst;
  assign state     = r_state;

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Main control FSM for the multicycle CPU, directly upstream of the register file.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives the register-file write enable (reg_write), writeback selects, memory/IR/PC enables and ALU controls from the instruction opcode.
- Moore machine: all outputs are a function of the current state only, except pc_en, which also uses zero.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch if equal
- OP_J, 6'b000010, jump
- OP_ADDI, 6'b001000, add immediate

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- opcode  input  6  instruction[31:26] from the instruction register
- zero  input  1  ALU zero flag
- pc_en  output  1  PC load enable = pc_write OR (pc_write_cond AND zero)
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read
- mem_write  output  1  memory write
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  register-file write data select: 0 = ALUOut, 1 = MDR
- reg_dst  output  1  write address select: 0 = rt, 1 = rd
- reg_write  output  1  register-file write enable
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- alu_op  output  2  00 = add, 01 = sub, 10 = use funct field
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  output  4  current state code, for debug
- illegal  output  1  high while in HALT

Behaviour:
- One state register, 4 bits. Asynchronous reset to FETCH. No other storage.
- State encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - EXEC 6, RWB 7, BEQ 8, JMP 9, ADDIEX 10, ADDIWB 11, HALT 15
  - Codes 12–14 are unused and go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE on opcode: LW/SW -> MEMADR; RTYPE -> EXEC; BEQ -> BEQ; J -> JMP; ADDI -> ADDIEX; any other opcode -> HALT.
  - MEMADR -> MEMRD if opcode == LW, else MEMWR.
  - MEMRD -> MEMWB.
  - EXEC -> RWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RWB, BEQ, JMP, ADDIWB -> FETCH.
  - HALT -> HALT until rst.
- Outputs per state. Any output not listed is 0.
  - FETCH: mem_read = 1, ir_write = 1, alu_src_b = 01, pc_write = 1.
  - DECODE: alu_src_b = 11 (branch target computed into ALUOut).
  - MEMADR: alu_src_a = 1, alu_src_b = 10.
  - MEMRD: mem_read = 1, iord = 1.
  - MEMWB: reg_write = 1, mem_to_reg = 1.
  - MEMWR: mem_write = 1, iord = 1.
  - EXEC: alu_src_a = 1, alu_op = 10.
  - RWB: reg_write = 1, reg_dst = 1.
  - BEQ: alu_src_a = 1, alu_op = 01, pc_write_cond = 1, pc_source = 01.
  - JMP: pc_write = 1, pc_source = 10.
  - ADDIEX: alu_src_a = 1, alu_src_b = 10.
  - ADDIWB: reg_write = 1.
  - HALT: all enables 0, illegal = 1.
- Cycles per instruction:
  - LW 5; SW, RTYPE and ADDI 4; BEQ and J 3.
  - Instructions are sampled in DECODE from the IR, which was loaded at the end of FETCH.
- While rst = 1, these outputs are forced to 0 regardless of state: pc_en, ir_write, mem_write, reg_write. The other outputs show FETCH values.
- pc_en is combinational from zero only in BEQ; zero is ignored in every other state.
- Reset mid-instruction: the state returns to FETCH immediately. No write enable may pulse during or after the reset edge.
- reg_write must be high for exactly one cycle per LW/RTYPE/ADDI instruction and never for SW/BEQ/J.

Test Plan:
- Reset: assert rst, release, then opcode = 6'h23 (LW). Required:
  - state = 0 during reset with reg_write = 0 and pc_en = 0.
  - After release, states 0→1→2→3→4→0.
  - reg_write = 1 and mem_to_reg = 1 only in state 4.
- RTYPE (opcode 0):
  - states 0,1,6,7; alu_op = 10 in state 6.
  - In state 7: reg_write = 1, reg_dst = 1, mem_to_reg = 0.
- BEQ (opcode 6'h04):
  - With zero = 1 in state 8: pc_en = 1, pc_source = 01.
  - Repeat with zero = 0: pc_en = 0.
  - Next state is 0 in both cases, 3 cycles total.
- SW (6'h2B) then J (6'h02):
  - SW: mem_write = 1 only in state 5, reg_write never 1.
  - J: state 9 with pc_en = 1, pc_source = 10.
- Illegal opcode 6'h3F:
  - After DECODE, state = 15 and illegal = 1.
  - Stays there for 20 cycles with all enables 0.
  - rst returns the FSM to 0.
- Async reset asserted mid-cycle while in state 7 (RWB):
  - reg_write drops immediately without waiting for a clock edge.
  - After release, execution restarts from FETCH.
